// File: rtl/mux_pkg.sv
// mux_pkg: shared types and helpers for the registered N:1 mux.
// Holds the FSM state type and the select-width helper.
package mux_pkg;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_GUARD  = 1'b1
    } mux_state_t;

    // clog2 that never returns less than one bit
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_guard_timer.sv
// mux_guard_timer: load/decrement down-counter for the blanking interval.
// Ports: clk, rst_n, load (preset to GUARD-1), dec (count down), done (count==0).
module mux_guard_timer
    import mux_pkg::*;
#(
    parameter int GUARD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(GUARD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg: registered N:1 mux with handshaked channel switch and guard blanking.
// Ports: in_data/in_valid (channels), sel_req/_valid/_ready (switch), cur_sel,
//        out_data/out_valid (registered sample), switching, sel_err (reject pulse).
module mux_nx1_reg
    import mux_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int WIDTH   = 8,
    parameter int GUARD   = 2,
    parameter int RST_SEL = 0,
    parameter int SEL_W   = sel_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [SEL_W-1:0]      sel_req,
    input  logic                  sel_req_valid,
    output logic                  sel_req_ready,
    output logic [SEL_W-1:0]      cur_sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  switching,
    output logic                  sel_err
);

    localparam bit HAS_GUARD = (GUARD > 0);
    localparam logic [SEL_W-1:0] RST_SEL_V = SEL_W'(RST_SEL);

    mux_state_t       state;
    logic [WIDTH-1:0] sel_data;
    logic             sel_valid;
    logic             sel_fire;
    logic             sel_bad;
    logic             sel_new;
    logic             sel_load;
    logic             guard_done;

    assign sel_req_ready = (state == ST_ACTIVE);
    assign switching     = (state == ST_GUARD);

    assign sel_data  = in_data[int'(cur_sel)*WIDTH +: WIDTH];
    assign sel_valid = in_valid[cur_sel];

    assign sel_fire = sel_req_valid && sel_req_ready;
    assign sel_bad  = (int'(sel_req) >= N_CH);
    assign sel_new  = !sel_bad && (sel_req != cur_sel);
    assign sel_load = sel_fire && sel_new;

    if (HAS_GUARD) begin : g_timer
        mux_guard_timer #(
            .GUARD(GUARD)
        ) u_timer (
            .clk  (clk),
            .rst_n(rst_n),
            .load (sel_load),
            .dec  (switching),
            .done (guard_done)
        );
    end else begin : g_no_timer
        assign guard_done = 1'b1;
    end

    // Output register samples the old channel on the accepting edge;
    // the new cur_sel takes effect from the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACTIVE;
            cur_sel   <= RST_SEL_V;
            out_data  <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= 1'b0;
            unique case (state)
                ST_ACTIVE: begin
                    out_data  <= sel_data;
                    out_valid <= sel_valid;
                    if (sel_fire && sel_bad) begin
                        sel_err <= 1'b1;
                    end else if (sel_load) begin
                        cur_sel <= sel_req;
                        if (HAS_GUARD) begin
                            state <= ST_GUARD;
                        end
                    end
                end
                ST_GUARD: begin
                    out_valid <= 1'b0;
                    if (guard_done) begin
                        state <= ST_ACTIVE;
                    end
                end
                default: state <= ST_ACTIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_nx1_reg.sv
// tb_mux_nx1_reg: scoreboard bench for mux_nx1_reg.
// Two instances: A (N_CH=4, GUARD=2, RST_SEL=0) and B (N_CH=3, GUARD=0, RST_SEL=1).
module tb_mux_nx1_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid;
    logic [1:0]  a_sel_req;
    logic        a_sel_req_valid;
    logic        a_ready;
    logic [1:0]  a_cur_sel;
    logic [7:0]  a_out_data;
    logic        a_out_valid;
    logic        a_switching;
    logic        a_sel_err;

    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [1:0]  b_sel_req;
    logic        b_sel_req_valid;
    logic        b_ready;
    logic [1:0]  b_cur_sel;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_switching;
    logic        b_sel_err;

    mux_nx1_reg #(
        .N_CH(4), .WIDTH(8), .GUARD(2), .RST_SEL(0)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (a_in_data),
        .in_valid     (a_in_valid),
        .sel_req      (a_sel_req),
        .sel_req_valid(a_sel_req_valid),
        .sel_req_ready(a_ready),
        .cur_sel      (a_cur_sel),
        .out_data     (a_out_data),
        .out_valid    (a_out_valid),
        .switching    (a_switching),
        .sel_err      (a_sel_err)
    );

    mux_nx1_reg #(
        .N_CH(3), .WIDTH(8), .GUARD(0), .RST_SEL(1)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (b_in_data),
        .in_valid     (b_in_valid),
        .sel_req      (b_sel_req),
        .sel_req_valid(b_sel_req_valid),
        .sel_req_ready(b_ready),
        .cur_sel      (b_cur_sel),
        .out_data     (b_out_data),
        .out_valid    (b_out_valid),
        .switching    (b_switching),
        .sel_err      (b_sel_err)
    );

    typedef struct {
        int         cyc;
        bit         dut;
        logic       v;
        logic [7:0] d;
        logic [1:0] sel;
        logic       sw;
        logic       err;
        logic       rdy;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, want);
        end
    endtask

    task automatic push(input bit dut, input logic v, input logic [7:0] d,
                        input logic [1:0] sel, input logic sw,
                        input logic err, input logic rdy);
        exp_t e;
        e.cyc = cyc + 1;
        e.dut = dut;
        e.v   = v;
        e.d   = d;
        e.sel = sel;
        e.sw  = sw;
        e.err = err;
        e.rdy = rdy;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk("slot", e.cyc, cyc);
                if (!e.dut) begin
                    chk("a_valid", a_out_valid, e.v);
                    chk("a_data", a_out_data, e.d);
                    chk("a_sel", a_cur_sel, e.sel);
                    chk("a_switching", a_switching, e.sw);
                    chk("a_sel_err", a_sel_err, e.err);
                    chk("a_ready", a_ready, e.rdy);
                end else begin
                    chk("b_valid", b_out_valid, e.v);
                    chk("b_data", b_out_data, e.d);
                    chk("b_sel", b_cur_sel, e.sel);
                    chk("b_switching", b_switching, e.sw);
                    chk("b_sel_err", b_sel_err, e.err);
                    chk("b_ready", b_ready, e.rdy);
                end
            end
        end
    end

    initial begin : stim
        rst_n           = 1'b0;
        a_in_data       = {8'h77, 8'h3C, 8'h5A, 8'hA5};
        a_in_valid      = 4'hF;
        a_sel_req       = 2'd0;
        a_sel_req_valid = 1'b0;
        b_in_data       = {8'h32, 8'h21, 8'h10};
        b_in_valid      = 3'b111;
        b_sel_req       = 2'd0;
        b_sel_req_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_data", a_out_data, 8'h00);
        chk("rst_a_valid", a_out_valid, 1'b0);
        chk("rst_a_sel", a_cur_sel, 2'd0);
        chk("rst_a_ready", a_ready, 1'b1);
        chk("rst_a_switching", a_switching, 1'b0);
        chk("rst_a_sel_err", a_sel_err, 1'b0);
        chk("rst_b_sel", b_cur_sel, 2'd1);
        chk("rst_b_valid", b_out_valid, 1'b0);

        rst_n = 1'b1;
        push(0, 1, 8'hA5, 0, 0, 0, 1);
        push(1, 1, 8'h21, 1, 0, 0, 1);
        tick();

        // A: 0->2 with guard; request held through guard becomes a no-op
        a_sel_req = 2'd2; a_sel_req_valid = 1'b1;
        push(0, 1, 8'hA5, 2, 1, 0, 0); tick();
        push(0, 0, 8'hA5, 2, 1, 0, 0); tick();
        push(0, 0, 8'hA5, 2, 0, 0, 1); tick();
        push(0, 1, 8'h3C, 2, 0, 0, 1); tick();
        a_sel_req_valid = 1'b0;
        a_in_data[23:16] = 8'h3D;
        push(0, 1, 8'h3D, 2, 0, 0, 1); tick();
        a_in_valid[2] = 1'b0;
        a_in_valid[3] = 1'b0;
        a_in_data[31:24] = 8'hEE;
        push(0, 0, 8'h3D, 2, 0, 0, 1); tick();
        a_in_valid = 4'hF;
        a_in_data[31:24] = 8'h77;
        a_in_data[7:0] = 8'h11;
        push(0, 1, 8'h3D, 2, 0, 0, 1); tick();

        // A: 2->0
        a_sel_req = 2'd0; a_sel_req_valid = 1'b1;
        push(0, 1, 8'h3D, 0, 1, 0, 0); tick();
        a_sel_req_valid = 1'b0;
        push(0, 0, 8'h3D, 0, 1, 0, 0); tick();
        push(0, 0, 8'h3D, 0, 0, 0, 1); tick();
        push(0, 1, 8'h11, 0, 0, 0, 1); tick();

        // A: 0->3; a new request for 1 arrives during guard and waits
        a_sel_req = 2'd3; a_sel_req_valid = 1'b1;
        push(0, 1, 8'h11, 3, 1, 0, 0); tick();
        a_sel_req = 2'd1;
        push(0, 0, 8'h11, 3, 1, 0, 0); tick();
        push(0, 0, 8'h11, 3, 0, 0, 1); tick();
        push(0, 1, 8'h77, 1, 1, 0, 0); tick();
        a_sel_req_valid = 1'b0;
        push(0, 0, 8'h77, 1, 1, 0, 0); tick();
        push(0, 0, 8'h77, 1, 0, 0, 1); tick();
        push(0, 1, 8'h5A, 1, 0, 0, 1); tick();

        // B: same-channel, out-of-range x2, bubble-free switch
        b_sel_req = 2'd1; b_sel_req_valid = 1'b1;
        push(1, 1, 8'h21, 1, 0, 0, 1); tick();
        push(1, 1, 8'h21, 1, 0, 0, 1); tick();
        b_sel_req = 2'd3;
        push(1, 1, 8'h21, 1, 0, 1, 1); tick();
        push(1, 1, 8'h21, 1, 0, 1, 1); tick();
        b_sel_req = 2'd2;
        push(1, 1, 8'h21, 2, 0, 0, 1); tick();
        b_sel_req_valid = 1'b0;
        push(1, 1, 8'h32, 2, 0, 0, 1); tick();
        b_in_data[23:16] = 8'h33;
        push(1, 1, 8'h33, 2, 0, 0, 1); tick();
        b_in_valid[0] = 1'b0;
        b_in_data[7:0] = 8'hFF;
        push(1, 1, 8'h33, 2, 0, 0, 1); tick();

        // A: back to 0, then reset in the middle of a 0->3 guard
        a_sel_req = 2'd0; a_sel_req_valid = 1'b1;
        push(0, 1, 8'h5A, 0, 1, 0, 0); tick();
        a_sel_req_valid = 1'b0;
        push(0, 0, 8'h5A, 0, 1, 0, 0); tick();
        push(0, 0, 8'h5A, 0, 0, 0, 1); tick();
        push(0, 1, 8'h11, 0, 0, 0, 1); tick();
        a_sel_req = 2'd3; a_sel_req_valid = 1'b1;
        push(0, 1, 8'h11, 3, 1, 0, 0); tick();
        a_sel_req_valid = 1'b0;
        push(0, 0, 8'h11, 3, 1, 0, 0); tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", a_cur_sel, 2'd0);
        chk("mid_rst_valid", a_out_valid, 1'b0);
        chk("mid_rst_switching", a_switching, 1'b0);
        chk("mid_rst_ready", a_ready, 1'b1);
        chk("mid_rst_data", a_out_data, 8'h00);

        tick();
        rst_n = 1'b1;
        push(0, 1, 8'h11, 0, 0, 0, 1); tick();
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
